// File: rtl/ch_uart_streamer_if.sv
// rtl/ch_uart_streamer_if.sv - FIFO-read and UART-transmit handshake bundle for ch_uart_streamer
interface ch_uart_streamer_if #(
   parameter int NUM_CH = 4,
   parameter int DATA_W = 16
);
   logic [NUM_CH-1:0]        fifo_empty;
   logic [NUM_CH-1:0]        fifo_rd;
   logic [NUM_CH*DATA_W-1:0] fifo_data;
   logic [7:0]               tx_data;
   logic                     tx_start;
   logic                     tx_done;

   modport master (
      input  fifo_empty, fifo_data, tx_done,
      output fifo_rd, tx_data, tx_start
   );

   modport slave (
      output fifo_empty, fifo_data, tx_done,
      input  fifo_rd, tx_data, tx_start
   );
endinterface

// File: rtl/ch_uart_streamer.sv
// rtl/ch_uart_streamer.sv - packs one word per channel into a byte frame for a UART transmitter
// Define CH_UART_STREAMER_HDR_EN to prefix every frame with HDR_BYTE.
module ch_uart_streamer #(
   parameter int         NUM_CH    = 4,
   parameter int         DATA_W    = 16,
   parameter int         MSB_FIRST = 0,
   parameter logic [7:0] HDR_BYTE  = 8'hA5
) (
   input  logic               clk40M,
   input  logic               nRst,
   input  logic               enable,
   ch_uart_streamer_if.master bus,
   output logic               busy,
   output logic [15:0]        frame_cnt
);
   localparam int BPW  = DATA_W / 8;
   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int BW_W = (BPW > 1) ? $clog2(BPW) : 1;

   typedef enum logic [2:0] {
      IDLE,
      LATCH,
`ifdef CH_UART_STREAMER_HDR_EN
      HDR,
`endif
      SEND,
      WAIT
   } state_t;

   state_t                   state, state_nx;
   logic [NUM_CH*DATA_W-1:0] shadow;
   logic [NUM_CH*DATA_W-1:0] shifted;
   logic [CH_W-1:0]          ch_idx;
   logic [BW_W-1:0]          bw_idx;
   logic [7:0]               tx_hold;
   logic [7:0]               cur_byte;
   logic [15:0]              frame_cnt_q;
   logic                     last_byte;
   int                       sel;
`ifdef CH_UART_STREAMER_HDR_EN
   logic                     hdr_phase;
`endif

   assign busy      = (state != IDLE);
   assign frame_cnt = frame_cnt_q;
   assign last_byte = (ch_idx == CH_W'(NUM_CH - 1)) && (bw_idx == BW_W'(BPW - 1));

   // Byte position within the word flips when the word goes out MSB first.
   always_comb begin
      sel      = (MSB_FIRST != 0) ? (BPW - 1 - int'(bw_idx)) : int'(bw_idx);
      shifted  = shadow >> (int'(ch_idx) * DATA_W + sel * 8);
      cur_byte = shifted[7:0];
   end

   always_ff @(posedge clk40M) begin
      if (!nRst) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx     = state;
      bus.fifo_rd  = '0;
      bus.tx_start = 1'b0;
      bus.tx_data  = tx_hold;
      case (state)
         IDLE: begin
            if (nRst && enable && !(|bus.fifo_empty)) begin
               bus.fifo_rd = '1;
               state_nx    = LATCH;
            end
         end
`ifdef CH_UART_STREAMER_HDR_EN
         LATCH: state_nx = HDR;
         HDR: begin
            bus.tx_start = 1'b1;
            bus.tx_data  = HDR_BYTE;
            state_nx     = WAIT;
         end
`else
         LATCH: state_nx = SEND;
`endif
         SEND: begin
            bus.tx_start = 1'b1;
            bus.tx_data  = cur_byte;
            state_nx     = WAIT;
         end
         WAIT: begin
            if (bus.tx_done) begin
`ifdef CH_UART_STREAMER_HDR_EN
               if (hdr_phase)      state_nx = SEND;
               else
`endif
               if (last_byte)      state_nx = IDLE;
               else                state_nx = SEND;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk40M) begin
      if (!nRst) begin
         shadow      <= '0;
         ch_idx      <= '0;
         bw_idx      <= '0;
         tx_hold     <= '0;
         frame_cnt_q <= '0;
`ifdef CH_UART_STREAMER_HDR_EN
         hdr_phase   <= 1'b0;
`endif
      end else begin
         case (state)
            LATCH: begin
               shadow <= bus.fifo_data;
               ch_idx <= '0;
               bw_idx <= '0;
            end
`ifdef CH_UART_STREAMER_HDR_EN
            HDR: begin
               tx_hold   <= HDR_BYTE;
               hdr_phase <= 1'b1;
            end
`endif
            SEND: tx_hold <= cur_byte;
            WAIT: begin
               if (bus.tx_done) begin
`ifdef CH_UART_STREAMER_HDR_EN
                  if (hdr_phase) hdr_phase <= 1'b0;
                  else
`endif
                  if (last_byte) begin
                     frame_cnt_q <= frame_cnt_q + 16'd1;
                  end else if (bw_idx == BW_W'(BPW - 1)) begin
                     bw_idx <= '0;
                     ch_idx <= ch_idx + CH_W'(1);
                  end else begin
                     bw_idx <= bw_idx + BW_W'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end
endmodule
